clock_hms_ctrl: RTL and testbench
=================================

Name: clock_hms_ctrl

Overview:
Parametrised 24 h timekeeping core with built-in time-set state machine, 12/24 h display conversion and blink gating. It accepts pre-debounced single-cycle button pulses and drives packed-BCD sec/min/hour fields plus per-field display enables to the 7-seg decoders. It generalises the fixed-rate clock24 datapath: the clock rate is a parameter, and the block adds field freeze during setting and an optional alarm.

Parameters:
CLK_HZ, 50000000, input clock frequency; prescaler modulus (>=2)
ALARM_SEC, 60, alarm output duration in seconds (1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_mode  input  1  single-cycle pulse; enter/leave set mode
btn_select  input  1  single-cycle pulse; next field in set mode
btn_adjust  input  1  single-cycle pulse; adjust selected field
mode12  input  1  1 = 12 h display, 0 = 24 h
alarm_edit  input  1  1 = adjusts and display target alarm registers
sec_bcd  output  8  seconds {tens,ones} BCD
min_bcd  output  8  minutes BCD
hour_bcd  output  8  hours BCD (12/24 converted)
pm  output  1  1 when mode12=1 and internal hour >= 12
tick1hz  output  1  one-cycle pulse per counted second
sec_on, min_on, hour_on  output  1 each  display enables (blink)
alarm  output  1  alarm active

Behaviour:
- Reset: time 00:00:00, prescaler 0, state NORMAL, tick1hz=0, alarm=0, alarm regs 00:00, all *_on=1. hour_bcd=0x00 (24 h) / 0x12 (12 h). pm=0.
- Prescaler: 0..CLK_HZ-1, always running, wraps at CLK_HZ-1. Wrap cycle = second boundary.
- tick1hz: asserted on the wrap cycle only in state NORMAL. Time advances on the same edge. sec 59->00 carries min, min 59->00 carries hour, hour 23->00.
- Time counters are internal BCD with registered outputs. Output latency: 1 cycle after the state change.
- FSM states: NORMAL, SET_SEC, SET_MIN, SET_HOUR.
  - btn_mode: NORMAL->SET_SEC; any SET_*->NORMAL.
  - btn_select: SET_SEC->SET_MIN->SET_HOUR->SET_SEC; ignored in NORMAL.
  - btn_adjust in SET_SEC: sec:=00 and prescaler:=0.
  - btn_adjust in SET_MIN: min+1, wraps 59->00, no carry.
  - btn_adjust in SET_HOUR: hour+1, wraps 23->00.
  - btn_adjust is ignored in NORMAL.
- Simultaneous pulses: only the highest priority acts (mode > select > adjust).
- Time is frozen in SET_* (no tick). Counting resumes at the next wrap after returning to NORMAL.
- Blink phase = (prescaler < CLK_HZ/2).
  - NORMAL: all *_on=1.
  - SET_X: the X field's *_on = blink phase; the other fields' enables = 1.
- 12 h conversion: internal 0->12; 1..12 unchanged; 13..23 -> 1..11. pm = mode12 & (hour >= 12). Conversion is combinational into the output register.
- mode12 may change any cycle. It affects display only, never the count.
- rst has priority over every input in the same cycle.

Optional Feature:
Macro CLOCK_ALARM_EN.
- Defined:
  - Alarm hour/min registers exist.
  - With alarm_edit=1 in SET_MIN/SET_HOUR, adjust increments the alarm field instead of the time, and min_bcd/hour_bcd show alarm values.
  - With alarm_edit=1, SET_SEC adjust is ignored and sec_bcd shows 00.
  - Trigger: in NORMAL, on the tick that makes time == alarm hh:mm:00, alarm goes high on that edge.
  - alarm stays high for ALARM_SEC ticks, or until any button pulse. That pulse is consumed and causes no FSM action.
  - Leaving NORMAL clears alarm.
- Undefined: alarm_edit is ignored, alarm is tied 0, no alarm registers. All ports remain present.

Test Plan:
- Reset, CLK_HZ=10, run 10 cycles: one tick1hz, sec_bcd=0x01. Run 590 more cycles: min_bcd=0x01, sec_bcd=0x00.
- Preload via SET_HOUR to 23, SET_MIN to 59, SET_SEC clear, return to NORMAL, wait 60 ticks: 00:00:00 and hour wrap verified.
- mode=1 in NORMAL, then SET_MIN: min_on toggles 5/5 cycles, sec_on=hour_on=1, no tick1hz while in SET_*.
- Hour=13, mode12=1: hour_bcd=0x01, pm=1. Hour=0: hour_bcd=0x12, pm=0. mode12=0 with hour=13: hour_bcd=0x13, pm=0.
- Mode, select and adjust pulsed in the same cycle in NORMAL: only mode acts, state SET_SEC, time unchanged. rst mid SET_HOUR: NORMAL, 00:00:00 next cycle.
- CLOCK_ALARM_EN, ALARM_SEC=3, alarm 00:01: alarm rises with the 00:01:00 tick and falls after 3 ticks. Repeat with btn_select during alarm: alarm falls next cycle and state stays NORMAL.

Source files
------------

// File: rtl/clock_hms_ctrl.sv
// 24 h BCD timekeeping core with time-set FSM, 12/24 h display conversion and blink gating.
// Define CLOCK_ALARM_EN to add the alarm hh:mm registers and the timed alarm output.
module clock_hms_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int ALARM_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_select,
  input  logic       btn_adjust,
  input  logic       mode12,
  input  logic       alarm_edit,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic       tick1hz,
  output logic       sec_on,
  output logic       min_on,
  output logic       hour_on,
  output logic       alarm
);
  localparam int            PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

  localparam logic [1:0] S_NORMAL = 2'd0;
  localparam logic [1:0] S_SEC    = 2'd1;
  localparam logic [1:0] S_MIN    = 2'd2;
  localparam logic [1:0] S_HOUR   = 2'd3;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [PW-1:0] pre;
  logic [1:0]    state;
  logic [7:0]    sec_r, min_r, hour_r;
  logic [7:0]    sec_nx, min_nx, hour_nx;
  logic          wrap, tick, blink;
  logic          edit, consume, show_al;
  logic          do_mode, do_sel, do_adj;

  assign wrap    = (pre == PRE_MAX);
  assign tick    = wrap && (state == S_NORMAL);
  assign blink   = (pre < PRE_HALF);
  assign tick1hz = tick;

  // One action per cycle: mode beats select beats adjust; a pulse that silences the alarm does nothing else.
  assign do_mode = btn_mode & ~consume;
  assign do_sel  = btn_select & ~btn_mode & ~consume & (state != S_NORMAL);
  assign do_adj  = btn_adjust & ~btn_mode & ~btn_select & ~consume & (state != S_NORMAL);

  always_comb begin
    sec_nx  = sec_r;
    min_nx  = min_r;
    hour_nx = hour_r;
    if (tick) begin
      sec_nx = bcd_inc(sec_r, 8'h59);
      if (sec_r == 8'h59) begin
        min_nx = bcd_inc(min_r, 8'h59);
        if (min_r == 8'h59) hour_nx = bcd_inc(hour_r, 8'h23);
      end
    end else if (do_adj && !edit) begin
      case (state)
        S_SEC:   sec_nx  = 8'h00;
        S_MIN:   min_nx  = bcd_inc(min_r, 8'h59);
        S_HOUR:  hour_nx = bcd_inc(hour_r, 8'h23);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      state  <= S_NORMAL;
      sec_r  <= 8'h00;
      min_r  <= 8'h00;
      hour_r <= 8'h00;
    end else begin
      // Clearing seconds also realigns the second boundary.
      pre    <= (wrap || (do_adj && !edit && state == S_SEC)) ? '0 : pre + 1'b1;
      sec_r  <= sec_nx;
      min_r  <= min_nx;
      hour_r <= hour_nx;
      if (do_mode)     state <= (state == S_NORMAL) ? S_SEC : S_NORMAL;
      else if (do_sel) state <= (state == S_HOUR) ? S_SEC : state + 2'd1;
    end
  end

`ifdef CLOCK_ALARM_EN
  logic [7:0] al_min, al_hour, al_left;
  logic       alarm_r;

  assign edit    = alarm_edit;
  assign consume = alarm_r & (btn_mode | btn_select | btn_adjust);
  assign show_al = alarm_edit && (state != S_NORMAL);
  assign alarm   = alarm_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      al_min  <= 8'h00;
      al_hour <= 8'h00;
      al_left <= 8'h00;
      alarm_r <= 1'b0;
    end else begin
      if (do_adj && edit && state == S_MIN)  al_min  <= bcd_inc(al_min, 8'h59);
      if (do_adj && edit && state == S_HOUR) al_hour <= bcd_inc(al_hour, 8'h23);
      if (consume || (do_mode && state == S_NORMAL)) begin
        alarm_r <= 1'b0;
      end else if (tick && {hour_nx, min_nx, sec_nx} == {al_hour, al_min, 8'h00}) begin
        alarm_r <= 1'b1;
        al_left <= 8'(ALARM_SEC);
      end else if (tick && alarm_r) begin
        if (al_left == 8'd1) alarm_r <= 1'b0;
        al_left <= al_left - 8'd1;
      end
    end
  end
`else
  logic       unused_alarm_edit;
  logic [7:0] unused_alarm_sec;
  assign unused_alarm_edit = alarm_edit;
  assign unused_alarm_sec  = 8'(ALARM_SEC);
  assign edit    = 1'b0;
  assign consume = 1'b0;
  assign show_al = 1'b0;
  assign alarm   = 1'b0;
`endif

  logic [7:0] d_sec, d_min, d_hour, h12;
  logic [4:0] h_bin, h12_bin;

  always_comb begin
    d_sec  = show_al ? 8'h00 : sec_r;
`ifdef CLOCK_ALARM_EN
    d_min  = show_al ? al_min  : min_r;
    d_hour = show_al ? al_hour : hour_r;
`else
    d_min  = min_r;
    d_hour = hour_r;
`endif
    h_bin = 5'(d_hour[7:4]) * 5'd10 + 5'(d_hour[3:0]);
    if (h_bin == 5'd0)       h12_bin = 5'd12;
    else if (h_bin > 5'd12)  h12_bin = h_bin - 5'd12;
    else                     h12_bin = h_bin;
    h12 = (h12_bin >= 5'd10) ? {4'd1, 4'(h12_bin - 5'd10)} : {4'd0, h12_bin[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_bcd  <= 8'h00;
      min_bcd  <= 8'h00;
      hour_bcd <= mode12 ? 8'h12 : 8'h00;
      pm       <= 1'b0;
    end else begin
      sec_bcd  <= d_sec;
      min_bcd  <= d_min;
      hour_bcd <= mode12 ? h12 : d_hour;
      pm       <= mode12 && (d_hour >= 8'h12);
    end
  end

  assign sec_on  = (state == S_SEC)  ? blink : 1'b1;
  assign min_on  = (state == S_MIN)  ? blink : 1'b1;
  assign hour_on = (state == S_HOUR) ? blink : 1'b1;

endmodule

// File: tb/tb_clock_hms_ctrl.sv
// Bench for clock_hms_ctrl: directed scenarios plus random button traffic against a seconds-of-day model.
module tb_clock_hms_ctrl;
  localparam int HZ   = 10;
  localparam int ASEC = 3;
`ifdef CLOCK_ALARM_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       btn_mode = 1'b0, btn_select = 1'b0, btn_adjust = 1'b0;
  logic       mode12 = 1'b0, alarm_edit = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       pm, tick1hz, sec_on, min_on, hour_on, alarm;

  int checks = 0, errors = 0;
  // Model: prescaler count, mode (0 run, 1 sec, 2 min, 3 hour), seconds of day, alarm minute of day.
  int m_pre, m_st, m_tod, m_al, m_left;
  bit m_aon;

  always #5 clk = ~clk;

  clock_hms_ctrl #(.CLK_HZ(HZ), .ALARM_SEC(ASEC)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_select(btn_select),
    .btn_adjust(btn_adjust), .mode12(mode12), .alarm_edit(alarm_edit),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .pm(pm),
    .tick1hz(tick1hz), .sec_on(sec_on), .min_on(min_on), .hour_on(hour_on),
    .alarm(alarm)
  );

  function automatic int bcd(int v);
    return (v / 10) * 16 + v % 10;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_st = 0; m_tod = 0; m_al = 0; m_left = 0; m_aon = 0;
  endtask

  task automatic model_edge();
    bit wrap, tick, ed, consumed, act_m, act_s, act_a;
    int old_st, h, mi, s;
    if (rst) begin
      model_reset();
      return;
    end
    ed = AL && alarm_edit;
    wrap = (m_pre == HZ - 1);
    tick = wrap && (m_st == 0);
    consumed = m_aon && (btn_mode || btn_select || btn_adjust);
    act_m = !consumed && btn_mode;
    act_s = !consumed && !btn_mode && btn_select;
    act_a = !consumed && !btn_mode && !btn_select && btn_adjust;
    old_st = m_st;
    if (act_a && old_st == 1 && !ed) m_pre = 0;
    else m_pre = wrap ? 0 : m_pre + 1;
    if (tick) m_tod = (m_tod + 1) % 86400;
    if (act_a && old_st != 0) begin
      if (ed) begin
        if (old_st == 2) m_al = (m_al / 60) * 60 + ((m_al % 60) + 1) % 60;
        if (old_st == 3) m_al = ((m_al / 60 + 1) % 24) * 60 + m_al % 60;
      end else begin
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        if (old_st == 1) s = 0;
        if (old_st == 2) mi = (mi + 1) % 60;
        if (old_st == 3) h = (h + 1) % 24;
        m_tod = h * 3600 + mi * 60 + s;
      end
    end
    if (act_m) m_st = (old_st == 0) ? 1 : 0;
    else if (act_s && old_st != 0) m_st = (old_st == 3) ? 1 : old_st + 1;
    if (consumed) m_aon = 0;
    else if (AL && tick && m_tod == m_al * 60) begin m_aon = 1; m_left = ASEC; end
    else if (tick && m_aon) begin m_left--; if (m_left == 0) m_aon = 0; end
    if (m_st != 0) m_aon = 0;
  endtask

  // One clock: check combinational outputs, predict the registered ones, advance, check.
  task automatic cyc();
    int hh, mm, ss, hd;
    bit show;
    logic [7:0] e_sec, e_min, e_hour;
    logic e_pm;
    chk("tick1hz", 32'(m_pre == HZ - 1 && m_st == 0), 32'(tick1hz));
    chk("sec_on",  32'(sec_on),  32'(m_st != 1 || m_pre < HZ / 2));
    chk("min_on",  32'(min_on),  32'(m_st != 2 || m_pre < HZ / 2));
    chk("hour_on", 32'(hour_on), 32'(m_st != 3 || m_pre < HZ / 2));
    show = AL && alarm_edit && m_st != 0;
    hh = show ? m_al / 60 : m_tod / 3600;
    mm = show ? m_al % 60 : (m_tod / 60) % 60;
    ss = show ? 0 : m_tod % 60;
    hd = !mode12 ? hh : (hh == 0) ? 12 : (hh > 12) ? hh - 12 : hh;
    e_sec = 8'(bcd(ss)); e_min = 8'(bcd(mm)); e_hour = 8'(bcd(hd));
    e_pm = mode12 && hh >= 12;
    if (rst) begin
      e_sec = 8'h00; e_min = 8'h00; e_hour = mode12 ? 8'h12 : 8'h00; e_pm = 1'b0;
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("sec_bcd",  32'(sec_bcd),  32'(e_sec));
    chk("min_bcd",  32'(min_bcd),  32'(e_min));
    chk("hour_bcd", 32'(hour_bcd), 32'(e_hour));
    chk("pm",       32'(pm),       32'(e_pm));
    chk("alarm",    32'(alarm),    32'(m_aon));
  endtask

  task automatic press(bit m, bit s, bit a);
    btn_mode = m; btn_select = s; btn_adjust = a;
    cyc();
    btn_mode = 1'b0; btn_select = 1'b0; btn_adjust = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 200 && m_aon; i++) cyc();
  endtask

  task automatic set_time(int h, int mi);
    settle();
    alarm_edit = 1'b0;
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 1, 0);
    repeat ((mi - (m_tod / 60) % 60 + 60) % 60) press(0, 0, 1);
    press(0, 1, 0);
    repeat ((h - m_tod / 3600 + 24) % 24) press(0, 0, 1);
    press(1, 0, 0);
  endtask

  task automatic set_alarm(int h, int mi);
    settle();
    alarm_edit = 1'b1;
    press(1, 0, 0);
    press(0, 1, 0);
    repeat ((mi - m_al % 60 + 60) % 60) press(0, 0, 1);
    press(0, 1, 0);
    repeat ((h - m_al / 60 + 24) % 24) press(0, 0, 1);
    press(1, 0, 0);
    alarm_edit = 1'b0;
  endtask

  initial begin
    int nt, nlo, nlo2, r;
    bit seen;
    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    do_reset();
    chk("rst_sec", 32'(sec_bcd), 32'h00);
    chk("rst_hour24", 32'(hour_bcd), 32'h00);
    mode12 = 1'b1;
    do_reset();
    chk("rst_hour12", 32'(hour_bcd), 32'h12);
    chk("rst_pm", 32'(pm), 32'd0);
    mode12 = 1'b0;

    // First second after reset, then first minute
    nt = 0;
    repeat (11) begin nt += int'(tick1hz); cyc(); end
    chk("ticks_first10", 32'(nt), 32'd1);
    chk("sec_after_10", 32'(sec_bcd), 32'h01);
    repeat (590) cyc();
    chk("min_after_600", 32'(min_bcd), 32'h01);
    chk("sec_after_600", 32'(sec_bcd), 32'h00);

    // Midnight rollover from 23:59:00
    set_time(23, 59);
    for (int i = 0; i < 800 && m_tod != 0; i++) cyc();
    cyc();
    chk("wrap_hour", 32'(hour_bcd), 32'h00);
    chk("wrap_min", 32'(min_bcd), 32'h00);
    chk("wrap_sec", 32'(sec_bcd), 32'h00);
    settle();

    // SET_MIN blink and frozen time
    press(1, 0, 0);
    press(0, 1, 0);
    nt = 0; nlo = 0; nlo2 = 0;
    repeat (30) begin
      nt += int'(tick1hz); nlo += int'(!min_on); nlo2 += int'(!sec_on || !hour_on);
      cyc();
    end
    chk("setmin_no_tick", 32'(nt), 32'd0);
    chk("setmin_blink_low", 32'(nlo), 32'd15);
    chk("setmin_others_on", 32'(nlo2), 32'd0);
    press(1, 0, 0);

    // 12/24 h conversion
    mode12 = 1'b1;
    set_time(13, 0);
    chk("h13_12h", 32'(hour_bcd), 32'h01);
    chk("h13_pm", 32'(pm), 32'd1);
    mode12 = 1'b0;
    cyc();
    chk("h13_24h", 32'(hour_bcd), 32'h13);
    chk("h13_pm24", 32'(pm), 32'd0);
    set_time(0, 0);
    mode12 = 1'b1;
    cyc();
    chk("h0_12h", 32'(hour_bcd), 32'h12);
    chk("h0_pm", 32'(pm), 32'd0);
    mode12 = 1'b0;

    // Simultaneous pulses: only mode acts
    settle();
    press(1, 1, 1);
    nlo = 0; nlo2 = 0;
    repeat (10) begin nlo += int'(!sec_on); nlo2 += int'(!min_on || !hour_on); cyc(); end
    chk("simul_sec_blink", 32'(nlo), 32'd5);
    chk("simul_others_on", 32'(nlo2), 32'd0);

    // Reset in the middle of SET_HOUR
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    do_reset();
    chk("rst_mid_sec", 32'(sec_bcd), 32'h00);
    chk("rst_mid_min", 32'(min_bcd), 32'h00);
    chk("rst_mid_hour", 32'(hour_bcd), 32'h00);
    chk("rst_mid_hour_on", 32'(hour_on), 32'd1);

`ifdef CLOCK_ALARM_EN
    // Alarm at 00:01, full duration
    do_reset();
    set_alarm(0, 1);
    seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin cyc(); seen = alarm; end
    chk("alarm_rise", 32'(seen), 32'd1);
    nt = 0;
    for (int i = 0; i < 100 && alarm; i++) begin nt += int'(tick1hz); cyc(); end
    chk("alarm_ticks", 32'(nt), 32'(ASEC));
    // Alarm silenced by a select pulse, FSM untouched
    do_reset();
    set_alarm(0, 1);
    seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin cyc(); seen = alarm; end
    chk("alarm_rise2", 32'(seen), 32'd1);
    btn_select = 1'b1;
    cyc();
    btn_select = 1'b0;
    chk("alarm_silenced", 32'(alarm), 32'd0);
    nt = 0; nlo = 0;
    repeat (10) begin nt += int'(tick1hz); nlo += int'(!sec_on || !min_on || !hour_on); cyc(); end
    chk("alarm_still_normal", 32'(nlo), 32'd0);
    chk("alarm_ticks_after", 32'(nt), 32'd1);
`endif

    // Random button traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 63));
      btn_mode   = (r == 0) || (r == 7);
      btn_select = (r == 1) || (r == 2) || (r == 7);
      btn_adjust = (r >= 3 && r <= 7) || (r >= 20 && r <= 27);
      if ($urandom_range(0, 99) == 0) mode12 = ~mode12;
      if ($urandom_range(0, 99) == 0) alarm_edit = ~alarm_edit;
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end
    btn_mode = 1'b0; btn_select = 1'b0; btn_adjust = 1'b0; rst = 1'b0;
    cyc();
`ifndef CLOCK_ALARM_EN
    chk("alarm_tied_low", 32'(alarm), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
